// File: rtl/rx_word_assembler_pkg.sv
// Shared definitions for the RX word assembly path: default word width and
// the serial bit-order selector.
package rx_word_assembler_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic {
    BIT_ORDER_LSB = 1'b0,  // first received bit lands in bit 0 (USB order)
    BIT_ORDER_MSB = 1'b1   // first received bit lands in bit DATA_WIDTH-1
  } bit_order_e;

endpackage

// File: rtl/rx_word_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module rx_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers alone
  // define which entries are meaningful, and a reset memory costs a mux per bit.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rx_word_assembler.sv
// Deserialises the bit-strobed RX stream into words, queues them behind a
// valid/ready handshake and flags alignment errors and overruns.
module rx_word_assembler
  import rx_word_assembler_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MSB_FIRST  = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  shift_en,
  input  logic                  serial_in,
  input  logic                  clear,
  input  logic                  eop,
  input  logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  word_rcv,
  output logic                  align_err,
  output logic                  overrun,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam bit_order_e ORDER = (MSB_FIRST != 0) ? BIT_ORDER_MSB : BIT_ORDER_LSB;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] shift_d;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic [CW-1:0]         bit_cnt_q;
  logic [CW-1:0]         cnt_post;
  logic                  last_bit;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    shift_d  = shift_q;
    cnt_post = bit_cnt_q;
    last_bit = shift_en && (bit_cnt_q == LAST_CNT);
    if (shift_en) begin
      if (ORDER == BIT_ORDER_MSB) shift_d = {shift_q[DATA_WIDTH-2:0], serial_in};
      else                        shift_d = {serial_in, shift_q[DATA_WIDTH-1:1]};
      cnt_post = last_bit ? '0 : bit_cnt_q + 1'b1;
    end
  end

  // clear wins over a same-cycle final bit, so that word never reaches the FIFO.
  assign push       = last_bit && !clear;
  assign data_valid = !fifo_empty;
  assign pop        = data_valid && data_ready;
  assign data_out   = data_valid ? fifo_rd_data : hold_q;

  rx_word_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push    (push),
    .wr_data (shift_d),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      hold_q     <= '0;
      word_rcv   <= 1'b0;
      align_err  <= 1'b0;
      overrun    <= 1'b0;
      word_count <= '0;
    end else begin
      word_rcv  <= 1'b0;
      align_err <= 1'b0;
      // Keeps data_out on the last delivered word once the FIFO runs dry.
      if (pop) hold_q <= fifo_rd_data;
      if (clear) begin
        bit_cnt_q  <= '0;
        word_count <= '0;
        overrun    <= 1'b0;
      end else begin
        shift_q <= shift_d;
        if (eop) begin
          bit_cnt_q <= '0;
          align_err <= (cnt_post != '0);
        end else begin
          bit_cnt_q <= cnt_post;
        end
        if (last_bit) begin
          word_rcv <= 1'b1;
          if (word_count != '1) word_count <= word_count + 1'b1;
          if (fifo_full && !pop) overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_word_assembler.sv
// Self-checking bench: an LSB-first and an MSB-first instance share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_rx_word_assembler;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       shift_en = 1'b0;
  logic       serial_in = 1'b0;
  logic       clear = 1'b0;
  logic       eop = 1'b0;
  logic       data_ready = 1'b0;

  logic [7:0] dout_l, dout_m;
  logic       dv_l, dv_m, rcv_l, rcv_m, ae_l, ae_m, ov_l, ov_m;
  logic [9:0] wc_l;
  logic [2:0] wc_m;

  int checks = 0;
  int passed = 0;

  // reference model state
  bit         part_q[$];
  logic [7:0] fifo_l[$];
  logic [7:0] fifo_m[$];
  logic [7:0] last_l, last_m;
  int         cnt_l, cnt_m;
  bit         m_ovr, m_rcv, m_aerr;

  always #5 clk = ~clk;

  rx_word_assembler #(.DATA_WIDTH(8), .MSB_FIRST(0), .FIFO_DEPTH(4), .CNT_WIDTH(10)) dut_l (
    .clk(clk), .n_rst(n_rst), .shift_en(shift_en), .serial_in(serial_in),
    .clear(clear), .eop(eop), .data_ready(data_ready),
    .data_out(dout_l), .data_valid(dv_l), .word_rcv(rcv_l),
    .align_err(ae_l), .overrun(ov_l), .word_count(wc_l)
  );

  rx_word_assembler #(.DATA_WIDTH(8), .MSB_FIRST(1), .FIFO_DEPTH(4), .CNT_WIDTH(3)) dut_m (
    .clk(clk), .n_rst(n_rst), .shift_en(shift_en), .serial_in(serial_in),
    .clear(clear), .eop(eop), .data_ready(data_ready),
    .data_out(dout_m), .data_valid(dv_m), .word_rcv(rcv_m),
    .align_err(ae_m), .overrun(ov_m), .word_count(wc_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    part_q.delete();
    fifo_l.delete();
    fifo_m.delete();
    last_l = '0;
    last_m = '0;
    cnt_l  = 0;
    cnt_m  = 0;
    m_ovr  = 0;
    m_rcv  = 0;
    m_aerr = 0;
  endfunction

  // One clock edge of the specified behaviour, using the inputs held across it.
  function automatic void model_edge();
    bit         pop;
    bit         push;
    logic [7:0] wl, wm;
    pop    = (fifo_l.size() > 0) && data_ready;
    push   = 0;
    wl     = '0;
    wm     = '0;
    m_rcv  = 0;
    m_aerr = 0;
    if (pop) begin
      last_l = fifo_l.pop_front();
      last_m = fifo_m.pop_front();
    end
    if (clear) begin
      part_q.delete();
      cnt_l = 0;
      cnt_m = 0;
      m_ovr = 0;
    end else begin
      if (shift_en) begin
        part_q.push_back(serial_in);
        if (part_q.size() == 8) begin
          for (int i = 0; i < 8; i++) begin
            wl[i]     = part_q[i];
            wm[7 - i] = part_q[i];
          end
          push = 1;
          part_q.delete();
        end
      end
      if (eop) begin
        m_aerr = (part_q.size() != 0);
        part_q.delete();
      end
      if (push) begin
        m_rcv = 1;
        cnt_l = (cnt_l < 1023) ? cnt_l + 1 : 1023;
        cnt_m = (cnt_m < 7) ? cnt_m + 1 : 7;
        if (fifo_l.size() < 4) begin
          fifo_l.push_back(wl);
          fifo_m.push_back(wm);
        end else begin
          m_ovr = 1;
        end
      end
    end
  endfunction

  task automatic check_all(input string tag);
    logic [7:0] exp_l, exp_m;
    exp_l = (fifo_l.size() > 0) ? fifo_l[0] : last_l;
    exp_m = (fifo_m.size() > 0) ? fifo_m[0] : last_m;
    chk({tag, ".valid_l"}, dv_l, fifo_l.size() > 0);
    chk({tag, ".valid_m"}, dv_m, fifo_m.size() > 0);
    chk({tag, ".data_l"}, dout_l, exp_l);
    chk({tag, ".data_m"}, dout_m, exp_m);
    chk({tag, ".rcv_l"}, rcv_l, m_rcv);
    chk({tag, ".rcv_m"}, rcv_m, m_rcv);
    chk({tag, ".aerr_l"}, ae_l, m_aerr);
    chk({tag, ".aerr_m"}, ae_m, m_aerr);
    chk({tag, ".ovr_l"}, ov_l, m_ovr);
    chk({tag, ".ovr_m"}, ov_m, m_ovr);
    chk({tag, ".cnt_l"}, wc_l, cnt_l);
    chk({tag, ".cnt_m"}, wc_m, cnt_m);
  endtask

  // Drive one cycle's inputs, advance the model across the edge, then compare.
  task automatic cyc(input string tag, input bit se, input bit sb, input bit cl,
                     input bit ep, input bit rdy);
    shift_en   = se;
    serial_in  = sb;
    clear      = cl;
    eop        = ep;
    data_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input bit rdy);
    cyc(tag, 0, 0, 0, 0, rdy);
  endtask

  // Bits go out LSB of w first; rdy_last applies on the final strobe.
  task automatic send_word(input string tag, input logic [7:0] w, input bit rdy,
                           input bit rdy_last);
    for (int i = 0; i < 8; i++) cyc(tag, 1, w[i], 0, 0, (i == 7) ? rdy_last : rdy);
  endtask

  initial begin
    logic [7:0] pat;
    model_reset();

    // reset state
    n_rst = 1'b0;
    #3;
    check_all("reset");
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // 1,0,1,1,0,0,1,0 -> 4D (LSB-first) / B2 (MSB-first)
    pat = 8'b0100_1101;
    send_word("lsb_word", pat, 1, 1);
    chk("plan.lsb_4d", dout_l, 8'h4D);
    chk("plan.msb_b2", dout_m, 8'hB2);
    chk("plan.valid_latency", dv_l, 1);
    chk("plan.rcv_pulse", rcv_l, 1);
    chk("plan.count_one", wc_l, 1);
    idle("pop_first", 1);
    chk("plan.valid_drop", dv_l, 0);

    // backpressure overflow then in-order drain
    cyc("bp_clear", 0, 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) send_word("bp_fill", 8'(k), 0, 0);
    chk("plan.bp_overrun", ov_l, 1);
    chk("plan.bp_count", wc_l, 5);
    for (int k = 1; k <= 4; k++) begin
      chk("plan.bp_order", dout_l, k);
      idle("bp_drain", 1);
    end
    chk("plan.bp_empty", dv_l, 0);
    chk("plan.bp_hold", dout_l, 8'h04);

    // full FIFO: fifth word completes on the same edge as a pop
    cyc("fp_clear", 0, 0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) send_word("fp_fill", 8'(k), 0, 0);
    send_word("fp_fifth", 8'h05, 0, 1);
    idle("fp_hold", 0);
    chk("plan.fp_no_overrun", ov_l, 0);
    for (int k = 2; k <= 5; k++) begin
      chk("plan.fp_order", dout_l, k);
      idle("fp_drain", 1);
    end

    // 11 bits then eop -> one word plus align_err
    for (int i = 0; i < 11; i++) cyc("al11", 1, 1'($urandom), 0, 0, 1);
    cyc("al11_eop", 0, 0, 0, 1, 1);
    chk("plan.align_err", ae_l, 1);
    idle("al11_after", 1);
    chk("plan.align_pulse", ae_l, 0);
    // 16 bits with eop on the last strobe -> two words, no align_err
    for (int i = 0; i < 16; i++) cyc("al16", 1, 1'($urandom), 0, i == 15, 1);
    chk("plan.align_clean", ae_l, 0);
    chk("plan.align_rcv", rcv_l, 1);

    // overrun, drain, partial word, clear, then A5
    for (int k = 0; k < 5; k++) send_word("cl_fill", 8'($urandom), 0, 0);
    for (int k = 0; k < 5; k++) idle("cl_drain", 1);
    chk("plan.cl_sticky", ov_l, 1);
    for (int i = 0; i < 3; i++) cyc("cl_part", 1, 1'($urandom), 0, 0, 0);
    cyc("cl_clear", 1, 1, 1, 1, 0);
    chk("plan.cl_overrun", ov_l, 0);
    send_word("cl_a5", 8'hA5, 0, 0);
    chk("plan.cl_a5", dout_l, 8'hA5);
    chk("plan.cl_count", wc_l, 1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      cyc("rand", $urandom_range(0, 9) < 6, 1'($urandom),
          $urandom_range(0, 149) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 1) == 1);
    end

    // reset with two words queued
    cyc("rs_clear", 0, 0, 1, 0, 1);
    idle("rs_flush", 1);
    idle("rs_flush", 1);
    idle("rs_flush", 1);
    idle("rs_flush", 1);
    send_word("rs_w1", 8'h3C, 0, 0);
    send_word("rs_w2", 8'hC3, 0, 0);
    for (int i = 0; i < 3; i++) cyc("rs_part", 1, 1, 0, 0, 0);
    chk("plan.rs_queued", dv_l, 1);
    n_rst = 1'b0;
    #1;
    model_reset();
    check_all("rs_async");
    @(posedge clk);
    #1;
    check_all("rs_held");
    n_rst = 1'b1;
    send_word("rs_after", 8'h5A, 1, 1);
    chk("plan.rs_after", dout_l, 8'h5A);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
